// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32x32 multiplier (radix-2 Booth) and
// 32/32 restoring divider feeding the HI/LO registers.
// Ports: clock, reset (async, active-high); start_mult/start_div requests
// with operands a/b; hi/lo results; busy, done and div_zero status pulses.
// Optional macro MULT_DIV_ZERO_DETECT_EN: short-circuit divide by zero.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef MULT_DIV_ZERO_DETECT_EN
  logic        dz_q, dz_d;
  logic        div_zero_q, div_zero_d;
`endif

  logic [31:0] a_mag, b_mag;
  logic [32:0] acc_ext, mcand_ext, booth_sum;
  logic [63:0] div_sh;
  logic [32:0] div_diff;
  logic        div_ok;
  logic [31:0] q_fin, r_fin;

  assign a_mag = a[31] ? -a : a;
  assign b_mag = b[31] ? -b : b;

  // Booth sum kept at 33 bits so subtracting the most negative
  // multiplicand cannot overflow; the shift drops it back to 32.
  assign acc_ext   = {work_q[64], work_q[64:33]};
  assign mcand_ext = {opnd_q[31], opnd_q};

  always_comb begin
    booth_sum = acc_ext;
    unique case (work_q[1:0])
      2'b01:   booth_sum = acc_ext + mcand_ext;
      2'b10:   booth_sum = acc_ext - mcand_ext;
      default: booth_sum = acc_ext;
    endcase
  end

  assign div_sh   = {work_q[62:0], 1'b0};
  assign div_diff = {1'b0, div_sh[63:32]} - {1'b0, opnd_q};
  assign div_ok   = ~div_diff[32];

  assign q_fin = qneg_q ? -work_q[31:0]  : work_q[31:0];
  assign r_fin = rneg_q ? -work_q[63:32] : work_q[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULT_DIV_ZERO_DETECT_EN
    dz_d       = 1'b0;
    div_zero_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d  = MULT_RUN;
          cnt_d    = 5'd31;
          opnd_d   = a;
          work_d   = {32'd0, b, 1'b0};
          is_div_d = 1'b0;
          qneg_d   = 1'b0;
          rneg_d   = 1'b0;
        end else if (start_div) begin
          state_d  = DIV_RUN;
          cnt_d    = 5'd31;
          opnd_d   = b_mag;
          work_d   = {33'd0, a_mag};
          is_div_d = 1'b1;
          qneg_d   = a[31] ^ b[31];
          rneg_d   = a[31];
`ifdef MULT_DIV_ZERO_DETECT_EN
          if (b == 32'd0) begin
            state_d = FINISH;
            dz_d    = 1'b1;
          end
`endif
        end
      end
      MULT_RUN: begin
        work_d = {booth_sum, work_q[32:1]};
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = FINISH;
      end
      DIV_RUN: begin
        work_d = {1'b0,
                  div_ok ? div_diff[31:0] : div_sh[63:32],
                  div_sh[31:1], div_ok};
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef MULT_DIV_ZERO_DETECT_EN
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else
`endif
        if (is_div_q) begin
          hi_d = r_fin;
          lo_d = q_fin;
        end else begin
          hi_d = work_q[64:33];
          lo_d = work_q[32:1];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      work_q   <= 65'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULT_DIV_ZERO_DETECT_EN
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULT_DIV_ZERO_DETECT_EN
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef MULT_DIV_ZERO_DETECT_EN
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed 32×32 multiplier and 32/32 divider that executes the MULT and DIV instructions on behalf of the multicycle control unit. The control unit pulses a start request and receives a one-cycle `done` when HI/LO are valid. The block is the datapath-side responder to the controller's 32-cycle MULT/DIV sequencing and feeds the HI and LO registers read by MFHI/MFLO.

## Interface
- No parameters; width fixed at 32.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; one clock, async active-high reset.
- `start_mult` in 1: request signed multiply of `a`×`b`; sampled only in IDLE.
- `start_div` in 1: request signed divide `a`/`b`; sampled only in IDLE.
- `a` in 32: operand A / dividend; latched on the accepting edge.
- `b` in 32: operand B / divisor; latched on the accepting edge.
- `hi` out 32: product[63:32] or remainder; reset 0.
- `lo` out 32: product[31:0] or quotient; reset 0.
- `busy` out 1: high in every state except IDLE; reset 0.
- `done` out 1: one-cycle pulse, `hi`/`lo` valid; reset 0.
- `div_zero` out 1: one-cycle pulse coincident with `done` when a DIV had `b`==0; reset 0.

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, FINISH.
- IDLE: `start_mult` → MULT_RUN; else `start_div` → DIV_RUN (mult wins if both high). Operands latched, `counter`←31, accumulators cleared.
- MULT_RUN: one radix-2 Booth step per cycle on a 65-bit {acc, multiplier, q-1} register, arithmetic right shift; `counter` decrements; step taken with `counter`==0 → FINISH.
- DIV_RUN: one restoring step per cycle on |a|, |b| magnitudes (64-bit remainder/quotient shift register); same counter rule → FINISH.
- FINISH: write `hi`/`lo`, pulse `done` (and `div_zero` if applicable), → IDLE.
- Multiply: full signed 64-bit product, no overflow possible.
- Divide: quotient truncates toward zero, negated if sign(a)≠sign(b); remainder takes sign of a. 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- `hi`/`lo` hold their value between operations; only FINISH updates them.
- Start requests while `busy` are ignored and not queued.
- Reset at any point: immediate IDLE, all outputs and internal registers 0, in-flight result discarded.

## Timing
- Edge E0 accepts start; `busy` high after E0.
- Steps on edges E1..E32; E32 moves to FINISH.
- E33: `hi`/`lo` written, `done`=1 for the cycle E33–E34, state IDLE, `busy` low after E33.
- New start may be sampled on E34 (IDLE, concurrent with the `done` cycle's end), giving 34-cycle back-to-back throughput.
- `done`, `busy`, `div_zero` are registered outputs; no combinational path from inputs.

## Configuration
- `MULT_DIV_ZERO_DETECT_EN` defined: DIV with `b`==0 goes IDLE→FINISH directly (done on E1), `div_zero`=1, `hi`/`lo` unchanged.
- Not defined: `div_zero` tied 0; divide by zero runs the full 33 cycles and yields hi=a, lo=0xFFFFFFFF if a≥0 else lo=0x00000001.

## Test plan
- MULT a=7, b=0xFFFFFFFD → `done` on E33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; `busy` high E0..E33 exactly.
- MULT a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV a=100, b=7 → lo=14, hi=2.
- Pulse `start_div` at cycle E10 of a running MULT, and both starts together in IDLE → first ignored, second performs MULT only.
- Assert `reset` at E15 of a DIV → all outputs 0 immediately, no `done`; new MULT afterwards completes normally.
- DIV a=5, b=0: with macro → `done`+`div_zero` on E1, hi/lo unchanged; without → `done` on E33, hi=5, lo=0xFFFFFFFF.
